// File: rtl/implication_queue_pkg.sv
// Shared types for the implication queue: FSM state encoding and the FIFO entry layout.
// Ports: none (package only).
// The entry carries a fixed-width variable index so the FIFO width does not depend on var_num.
package implication_queue_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    APPLY    = 2'd1,
    CHECK    = 2'd2,
    CONFLICT = 2'd3
  } state_t;

  // Wide enough for any practical var_num; implied indices are zero-extended into it.
  localparam int VAR_IDX_W = 16;

  typedef struct packed {
    logic [VAR_IDX_W-1:0] var_idx;
    logic                 value;
  } imp_entry_t;

endpackage

// File: rtl/implication_queue_fifo.sv
// imp_fifo: circular-buffer FIFO with synchronous clear; head entry is always visible on pop_data.
// Ports: clock/reset, clear (sync flush), push/push_data, pop/pop_data, empty/full.
// A push while full is accepted only when a pop happens in the same cycle; clear overrides both.
module imp_fifo #(
  parameter int width = 17,
  parameter int depth = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic [width-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(depth);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(depth);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [width-1:0] mem_q [depth];
  logic [width-1:0] mem_d [depth];
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_pop  = pop && (count_q != '0);
    // Full is only a barrier when nothing leaves this cycle.
    do_push = push && ((count_q != DEPTH_CNT) || do_pop);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;

    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
      end
      // Pointers are exactly log2(depth) bits, so they wrap modulo depth for free.
      wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
      rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
      count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_CNT);

endmodule

// File: rtl/implication_queue.sv
// Implication queue: buffers implied literals, applies them to the assignment state one at a time
// and hands each new assignment to the check unit; decisions enter only when nothing is pending.
// Ports: clock/reset/init_signal, imp_* (implication in), dec_* (decision in), check_* handshake,
// conflict_clear, free/assignment/conflict state out, empty/full FIFO status.
module implication_queue
  import implication_queue_pkg::*;
#(
  parameter int var_num = 8,
  parameter int depth   = 8
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   init_signal,
  input  logic                                   imp_valid,
  input  logic [((var_num > 1) ? $clog2(var_num) : 1)-1:0] imp_var,
  input  logic                                   imp_value,
  output logic                                   imp_ready,
  input  logic                                   dec_valid,
  input  logic [((var_num > 1) ? $clog2(var_num) : 1)-1:0] dec_var,
  input  logic                                   dec_value,
  output logic                                   dec_ready,
  output logic                                   check_request,
  input  logic                                   check_done,
  input  logic                                   check_conflict,
  input  logic                                   conflict_clear,
  output logic [var_num-1:0]                     free,
  output logic [var_num-1:0]                     assignment,
  output logic                                   conflict,
  output logic                                   empty,
  output logic                                   full
);

  localparam int IDX_W = (var_num > 1) ? $clog2(var_num) : 1;

  state_t               state_q, state_d;
  logic [var_num-1:0]   free_q, free_d;
  logic [var_num-1:0]   assignment_q, assignment_d;
  logic                 check_request_q, check_request_d;
  logic                 conflict_q, conflict_d;

  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_clear;
  logic                 fifo_empty;
  logic                 fifo_full;
  imp_entry_t           push_entry;
  imp_entry_t           head;
  logic [IDX_W-1:0]     head_idx;
  logic                 head_in_range;

  // While APPLY pops the head, a full FIFO still has room for one new entry this cycle.
  assign imp_ready = (!fifo_full || (state_q == APPLY)) && (state_q != CONFLICT);
  assign dec_ready = (state_q == IDLE) && fifo_empty;
  assign fifo_push = imp_valid && imp_ready;

  assign push_entry = '{var_idx: VAR_IDX_W'(imp_var), value: imp_value};

  imp_fifo #(
    .width ($bits(imp_entry_t)),
    .depth (depth)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (fifo_clear),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .pop_data  (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign head_in_range = (int'(head.var_idx) < var_num);
  assign head_idx      = head.var_idx[IDX_W-1:0];

  always_comb begin
    state_d         = state_q;
    free_d          = free_q;
    assignment_d    = assignment_q;
    check_request_d = 1'b0;
    conflict_d      = conflict_q;
    fifo_pop        = 1'b0;
    fifo_clear      = 1'b0;

    if (init_signal) begin
      state_d      = IDLE;
      free_d       = '1;
      assignment_d = '0;
      conflict_d   = 1'b0;
      fifo_clear   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Pending implications always drain before a new decision is taken.
          if (!fifo_empty) begin
            state_d = APPLY;
          end else if (dec_valid) begin
            free_d[dec_var]       = 1'b0;
            assignment_d[dec_var] = dec_value;
            check_request_d       = 1'b1;
            state_d               = CHECK;
          end
        end
        APPLY: begin
          fifo_pop = 1'b1;
          if (!head_in_range) begin
            state_d = IDLE;
          end else if (free_q[head_idx]) begin
            free_d[head_idx]       = 1'b0;
            assignment_d[head_idx] = head.value;
            check_request_d        = 1'b1;
            state_d                = CHECK;
          end else if (assignment_q[head_idx] == head.value) begin
            state_d = IDLE;
          end else begin
            state_d    = CONFLICT;
            conflict_d = 1'b1;
            fifo_clear = 1'b1;
          end
        end
        CHECK: begin
          if (check_done) begin
            if (check_conflict) begin
              state_d    = CONFLICT;
              conflict_d = 1'b1;
              fifo_clear = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        CONFLICT: begin
          // Backtracking is done elsewhere; the assignment state is left untouched here.
          if (conflict_clear) begin
            state_d    = IDLE;
            conflict_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      free_q          <= '1;
      assignment_q    <= '0;
      check_request_q <= 1'b0;
      conflict_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      free_q          <= free_d;
      assignment_q    <= assignment_d;
      check_request_q <= check_request_d;
      conflict_q      <= conflict_d;
    end
  end

  assign check_request = check_request_q;
  assign free          = free_q;
  assign assignment    = assignment_q;
  assign conflict      = conflict_q;
  assign empty         = fifo_empty;
  assign full          = fifo_full;

endmodule
